// File: rtl/tree_pkg.sv
// tree_pkg: shared defaults and types for the tree fan-in/fan-out nodes
package tree_pkg;
  localparam int DEF_NUM_CHILDREN = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ID_W = 3;
  localparam int DEF_CNT_W = 16;
  typedef logic [DEF_ID_W-1:0] child_idx_t;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    child_idx_t src_id;
  } beat_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin search of req starting at ptr -> one-hot gnt, gnt_idx, any_gnt
module rr_arbiter #(
  parameter int N = 5,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_gnt
);
  always_comb begin
    any_gnt = |req;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) gnt_idx = IDW'(i);
    for (int i = N - 1; i >= 0; i--) if (req[i] && i >= int'(ptr)) gnt_idx = IDW'(i);
    gnt = any_gnt ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/tree_node_fanin_merge.sv
// tree_node_fanin_merge: round-robin N:1 upward merge, registered tagged output beat, parent-accept counter
module tree_node_fanin_merge
  import tree_pkg::*;
#(
  parameter int NUM_CHILDREN = DEF_NUM_CHILDREN,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W = DEF_ID_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           up_valid,
  output logic [DATA_W-1:0]              up_data,
  output logic [ID_W-1:0]                up_src_id,
  input  logic                           up_ready,
  output logic [CNT_W-1:0]               xfer_count
);
  logic [NUM_CHILDREN-1:0] gnt;
  logic [ID_W-1:0] gnt_idx;
  logic any_gnt, load_en, take;
  logic up_valid_q, up_valid_d;
  logic [DATA_W-1:0] up_data_q, up_data_d;
  logic [ID_W-1:0] up_src_id_q, up_src_id_d, rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
  rr_arbiter #(.N(NUM_CHILDREN), .IDW(ID_W)) u_arb (
    .req(child_valid),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );
  always_comb begin
    load_en = !up_valid_q || up_ready;
    take = load_en && any_gnt;
    child_ready = (load_en && rst_n) ? gnt : '0;
    up_valid_d = take || (up_valid_q && !up_ready);
    up_data_d = take ? child_data[gnt_idx*DATA_W +: DATA_W] : up_data_q;
    up_src_id_d = take ? gnt_idx : up_src_id_q;
    rr_ptr_d = !take ? rr_ptr_q : (gnt_idx == ID_W'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + 1'b1;
    xfer_count_d = xfer_count_q + CNT_W'(up_valid_q && up_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_valid_q <= 1'b0;
      up_data_q <= '0;
      up_src_id_q <= '0;
      rr_ptr_q <= '0;
      xfer_count_q <= '0;
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q <= up_data_d;
      up_src_id_q <= up_src_id_d;
      rr_ptr_q <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end
  assign up_valid = up_valid_q;
  assign up_data = up_data_q;
  assign up_src_id = up_src_id_q;
  assign xfer_count = xfer_count_q;
endmodule

// File: tb/tb_tree_node_fanin_merge.sv
// tb_tree_node_fanin_merge: randomized and directed checks of the fan-in merge against a behavioural model
module tb_tree_node_fanin_merge;
  localparam int N = 5;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] cv = '0;
  logic [N*DW-1:0] cd = '0;
  logic [N-1:0] cr;
  logic uv;
  logic [DW-1:0] ud;
  logic [IW-1:0] us;
  logic ur = 1'b0;
  logic [CW-1:0] xc;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_v;
  logic [DW-1:0] m_d;
  int m_s;
  int m_ptr;
  logic [CW-1:0] m_c;
  logic [N-1:0] acc;
  int fair_w [N];
  tree_node_fanin_merge #(.NUM_CHILDREN(N), .DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .child_valid(cv), .child_data(cd), .child_ready(cr),
    .up_valid(uv), .up_data(ud), .up_src_id(us), .up_ready(ur), .xfer_count(xc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_v = 0; m_d = '0; m_s = 0; m_ptr = 0; m_c = '0; acc = '0;
    for (int c = 0; c < N; c++) fair_w[c] = 0;
  endtask
  task automatic tick();
    int g;
    bit load;
    logic [N-1:0] exp_r;
    @(negedge clk);
    load = !m_v || ur;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && cv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_r = '0;
    if (rst_n && load && g >= 0) exp_r[g] = 1'b1;
    chk("child_ready", 64'(cr), 64'(exp_r));
    chk("up_valid", 64'(uv), 64'(m_v));
    if (m_v) begin
      chk("up_data", 64'(ud), 64'(m_d));
      chk("up_src_id", 64'(us), 64'(m_s));
    end
    chk("xfer_count", 64'(xc), 64'(m_c));
    acc = exp_r;
    if (rst_n) begin
      if (m_v && ur) m_c++;
      if (exp_r != '0) begin
        for (int c = 0; c < N; c++) if (c != g && cv[c]) begin
          fair_w[c]++;
          chk("fair_wait", 64'(fair_w[c] > N - 1), 64'(0));
        end
        fair_w[g] = 0;
        m_d = cd[g*DW +: DW];
        m_s = g;
        m_v = 1;
        m_ptr = (g + 1) % N;
      end else if (ur) m_v = 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int pct);
    for (int c = 0; c < N; c++) begin
      if (acc[c]) cv[c] = 1'b0;
      if (!cv[c] && $urandom_range(0, 99) < pct) begin
        cv[c] = 1'b1;
        cd[c*DW +: DW] = DW'($urandom);
      end
    end
  endtask
  initial begin
    logic [DW-1:0] held;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    cv = 5'b01000;
    cd[3*DW +: DW] = 16'hA5A5;
    ur = 1'b1;
    tick();
    chk("single_valid", 64'(uv), 64'd1);
    chk("single_data", 64'(ud), 64'hA5A5);
    chk("single_src", 64'(us), 64'd3);
    chk("single_cnt_pre", 64'(xc), 64'd0);
    cv = '0;
    tick();
    chk("single_cnt", 64'(xc), 64'd1);
    chk("single_drain", 64'(uv), 64'd0);
    ur = 1'b0;
    drive(100);
    tick();
    held = ud;
    drive(100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_data", 64'(ud), 64'(held));
      chk("bp_ready_zero", 64'(cr), 64'd0);
      drive(100);
    end
    ur = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(100);
    end
    ur = 1'b0;
    tick();
    drive(100);
    rst_n = 1'b0;
    #1;
    chk("rst_up_valid", 64'(uv), 64'd0);
    chk("rst_count", 64'(xc), 64'd0);
    chk("rst_ready", 64'(cr), 64'd0);
    chk("rst_data", 64'(ud), 64'd0);
    chk("rst_src", 64'(us), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    cv = '1;
    ur = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_seq", 64'(us), 64'(i % N));
      chk("rr_nogap", 64'(uv), 64'd1);
      drive(100);
    end
    for (int i = 0; i < 70000 && m_c != 16'hFFFF; i++) begin
      tick();
      drive(100);
    end
    chk("wrap_pre", 64'(xc), 64'hFFFF);
    tick();
    chk("wrap_zero", 64'(xc), 64'd0);
    for (int i = 0; i < 10000; i++) begin
      drive(50);
      ur = ($urandom_range(0, 99) < 70);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
